// File: rtl/imm_gen_pkg.sv
// Shared format codes and helpers for the pipelined immediate generator.
// Optional PC-relative target output is enabled by defining IMM_GEN_PC_TARGET_EN.
package imm_gen_pkg;

  typedef logic [2:0] fmt_t;

  localparam fmt_t FMT_I     = 3'b000;
  localparam fmt_t FMT_U     = 3'b001;
  localparam fmt_t FMT_S     = 3'b010;
  localparam fmt_t FMT_J     = 3'b011;
  localparam fmt_t FMT_B     = 3'b100;
  localparam fmt_t FMT_CSR   = 3'b101;
  localparam fmt_t FMT_SHAMT = 3'b110;
  localparam fmt_t FMT_RSVD  = 3'b111;

  function automatic bit xlen_legal(int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  // Formats whose immediate is an offset from the instruction's PC.
  function automatic logic fmt_pc_rel(fmt_t fmt);
    return (fmt == FMT_U) || (fmt == FMT_J) || (fmt == FMT_B);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus of imm_gen_pipe; in_pc/out_target exist only with IMM_GEN_PC_TARGET_EN.
interface imm_gen_pipe_if
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  fmt_t             in_fmt;
  logic [31:0]      in_idata;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_fmt_err;
`ifdef IMM_GEN_PC_TARGET_EN
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  out_target;
`endif

  modport slave (
`ifdef IMM_GEN_PC_TARGET_EN
    input  in_pc,
    output out_target,
`endif
    input  in_valid, in_fmt, in_idata, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_fmt_err
  );

  modport master (
`ifdef IMM_GEN_PC_TARGET_EN
    output in_pc,
    input  out_target,
`endif
    output in_valid, in_fmt, in_idata, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_fmt_err
  );
endinterface

// File: rtl/imm_extract.sv
// Combinational immediate decode: selects instruction fields per format and extends to XLEN.
module imm_extract
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  fmt_t            fmt_i,
  input  logic [31:0]     idata_i,
  output logic [XLEN-1:0] imm_o,
  output logic            fmt_err_o
);

  logic [31:0] imm32;
  logic        sext;
  logic        unused_opcode;

  assign unused_opcode = ^idata_i[6:0];

  always_comb begin
    imm32     = '0;
    sext      = 1'b1;
    fmt_err_o = 1'b0;
    case (fmt_i)
      FMT_I:     imm32 = {{20{idata_i[31]}}, idata_i[31:20]};
      FMT_U:     imm32 = {idata_i[31:12], 12'b0};
      FMT_S:     imm32 = {{20{idata_i[31]}}, idata_i[31:25], idata_i[11:7]};
      FMT_J:     imm32 = {{12{idata_i[31]}}, idata_i[19:12], idata_i[20], idata_i[30:21], 1'b0};
      FMT_B:     imm32 = {{20{idata_i[31]}}, idata_i[7], idata_i[30:25], idata_i[11:8], 1'b0};
      FMT_CSR: begin
        imm32 = {27'b0, idata_i[19:15]};
        sext  = 1'b0;
      end
      FMT_SHAMT: begin
        imm32 = (XLEN == 64) ? {26'b0, idata_i[25:20]} : {27'b0, idata_i[24:20]};
        sext  = 1'b0;
      end
      default: begin
        sext      = 1'b0;
        fmt_err_o = 1'b1;
      end
    endcase
  end

  // Upper bits (XLEN=64) replicate bit 31 for signed formats, zero otherwise.
  always_comb begin
    imm_o        = {XLEN{sext & idata_i[31]}};
    imm_o[31:0]  = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: registered output stage plus 1-entry skid buffer.
// Define IMM_GEN_PC_TARGET_EN to add in_pc/out_target (pc + imm for U/J/B formats).
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input logic           clk,
  input logic           reset,
  imm_gen_pipe_if.slave bus
);

  if (!xlen_legal(XLEN)) begin : gen_xlen_illegal
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic             in_fire, out_load;
  logic             skid_valid_q, skid_valid_d;
  fmt_t             skid_fmt_q, skid_fmt_d;
  logic [31:0]      skid_idata_q, skid_idata_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_err_q, out_err_d;
  fmt_t             sel_fmt;
  logic [31:0]      sel_idata;
  logic [TAG_W-1:0] sel_tag;
  logic [XLEN-1:0]  sel_imm;
  logic             sel_err;
`ifdef IMM_GEN_PC_TARGET_EN
  logic [XLEN-1:0]  skid_pc_q, skid_pc_d, sel_pc;
  logic [XLEN-1:0]  out_target_q, out_target_d;
`endif

  // in_ready depends only on skid state and reset, never on out_ready.
  assign bus.in_ready = !skid_valid_q && !reset;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_load     = !out_valid_q || bus.out_ready;

  // A full skid always has priority; in_ready is low then, so no input can be lost.
  assign sel_fmt   = skid_valid_q ? skid_fmt_q   : bus.in_fmt;
  assign sel_idata = skid_valid_q ? skid_idata_q : bus.in_idata;
  assign sel_tag   = skid_valid_q ? skid_tag_q   : bus.in_tag;
`ifdef IMM_GEN_PC_TARGET_EN
  assign sel_pc    = skid_valid_q ? skid_pc_q    : bus.in_pc;
`endif

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .fmt_i    (sel_fmt),
    .idata_i  (sel_idata),
    .imm_o    (sel_imm),
    .fmt_err_o(sel_err)
  );

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_fmt_d   = skid_fmt_q;
    skid_idata_d = skid_idata_q;
    skid_tag_d   = skid_tag_q;
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
`ifdef IMM_GEN_PC_TARGET_EN
    skid_pc_d    = skid_pc_q;
    out_target_d = out_target_q;
`endif
    if (out_load) begin
      out_valid_d = skid_valid_q || in_fire;
      if (skid_valid_q || in_fire) begin
        out_imm_d = sel_imm;
        out_tag_d = sel_tag;
        out_err_d = sel_err;
`ifdef IMM_GEN_PC_TARGET_EN
        out_target_d = fmt_pc_rel(sel_fmt) ? sel_pc + sel_imm : '0;
`endif
      end
      skid_valid_d = 1'b0;
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_fmt_d   = bus.in_fmt;
      skid_idata_d = bus.in_idata;
      skid_tag_d   = bus.in_tag;
`ifdef IMM_GEN_PC_TARGET_EN
      skid_pc_d    = bus.in_pc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_fmt_q   <= FMT_I;
      skid_idata_q <= '0;
      skid_tag_q   <= '0;
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
`ifdef IMM_GEN_PC_TARGET_EN
      skid_pc_q    <= '0;
      out_target_q <= '0;
`endif
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_idata_q <= skid_idata_d;
      skid_tag_q   <= skid_tag_d;
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
`ifdef IMM_GEN_PC_TARGET_EN
      skid_pc_q    <= skid_pc_d;
      out_target_q <= out_target_d;
`endif
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.out_fmt_err = out_err_q;
`ifdef IMM_GEN_PC_TARGET_EN
  assign bus.out_target  = out_target_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe (XLEN=32 main instance, XLEN=64 side instance).
// Define IMM_GEN_PC_TARGET_EN to also exercise out_target.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  localparam int unsigned TW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(TW)) bus ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(TW)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(TW)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TW)) u_dut64 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus64.slave)
  );

  typedef struct packed {
    logic [31:0]   imm;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Field-by-field reference model, built at 64 bits and truncated by the caller.
  function automatic logic [63:0] ref_imm(logic [2:0] f, logic [31:0] d, int xl);
    logic [63:0] s;
    s = {64{d[31]}};
    case (f)
      FMT_I:     return {s[63:12], d[31:20]};
      FMT_U:     return {s[63:32], d[31:12], 12'h000};
      FMT_S:     return {s[63:12], d[31:25], d[11:7]};
      FMT_J:     return {s[63:20], d[19:12], d[20], d[30:21], 1'b0};
      FMT_B:     return {s[63:12], d[7], d[30:25], d[11:8], 1'b0};
      FMT_CSR:   return {59'd0, d[19:15]};
      FMT_SHAMT: return (xl == 64) ? {58'd0, d[25:20]} : {59'd0, d[24:20]};
      default:   return 64'd0;
    endcase
  endfunction

  function automatic exp_t make_exp(logic [2:0] f, logic [31:0] d, logic [TW-1:0] t);
    exp_t e;
    logic [63:0] r;
    r     = ref_imm(f, d, 32);
    e.imm = r[31:0];
    e.tag = t;
    e.err = (f == 3'b111);
    return e;
  endfunction

  task automatic drive_idle();
    bus.in_valid    = 1'b0;
    bus.in_fmt      = 3'b000;
    bus.in_idata    = '0;
    bus.in_tag      = '0;
    bus.out_ready   = 1'b0;
    bus64.in_valid  = 1'b0;
    bus64.in_fmt    = 3'b000;
    bus64.in_idata  = '0;
    bus64.in_tag    = '0;
    bus64.out_ready = 1'b1;
`ifdef IMM_GEN_PC_TARGET_EN
    bus.in_pc       = '0;
    bus64.in_pc     = '0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_in_ready_low: got %0b want 0", bus.in_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_imm !== 32'd0 || bus.out_tag !== 8'd0 || bus.out_fmt_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_out_data: got imm=%h tag=%h err=%b want 0", bus.out_imm, bus.out_tag,
               bus.out_fmt_err);
    end
`ifdef IMM_GEN_PC_TARGET_EN
    n_checks++;
    if (bus.out_target !== 32'd0) begin
      n_errors++; $display("FAIL reset_out_target: got %h want 0", bus.out_target);
    end
`endif
    tick();
    reset = 1'b0;
    #2;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_in_ready_after: got %0b want 1", bus.in_ready);
    end
    tick();
  endtask

  task automatic test_format_sweep();
    logic [31:0] tbl [8];
    tbl = '{32'hFFFFFFED, 32'hFEDCB000, 32'hFFFFFFE1, 32'hFFFCBFEC,
            32'hFFFFFFE0, 32'h00000019, 32'h0000000D, 32'h00000000};
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      bus.in_valid = (i < 8);
      bus.in_fmt   = 3'(i);
      bus.in_idata = 32'hFEDCB0E3;
      bus.in_tag   = 8'(i);
      #2;
      if (i > 0) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 8'(i - 1)) begin
          n_errors++;
          $display("FAIL sweep_latency fmt=%0d: got valid=%b tag=%0d want valid=1 tag=%0d", i - 1,
                   bus.out_valid, bus.out_tag, i - 1);
        end
        n_checks++;
        if (bus.out_imm !== tbl[i-1] || bus.out_fmt_err !== (i == 8)) begin
          n_errors++;
          $display("FAIL sweep_imm fmt=%0d: got imm=%h err=%b want imm=%h err=%b", i - 1,
                   bus.out_imm, bus.out_fmt_err, tbl[i-1], (i == 8));
        end
      end
      if (i < 8) begin
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
          n_errors++; $display("FAIL sweep_in_ready cyc=%0d: got %b want 1", i, bus.in_ready);
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_xlen64();
    bus64.out_ready = 1'b1;
    bus64.in_valid  = 1'b1;
    bus64.in_fmt    = FMT_U;
    bus64.in_idata  = 32'h80000037;
    tick();
    bus64.in_fmt    = FMT_SHAMT;
    bus64.in_idata  = 32'h03F01013;
    #2;
    n_checks++;
    if (bus64.out_valid !== 1'b1 || bus64.out_imm !== 64'hFFFFFFFF80000000) begin
      n_errors++;
      $display("FAIL x64_u: got valid=%b imm=%h want 1 ffffffff80000000", bus64.out_valid,
               bus64.out_imm);
    end
    tick();
    bus64.in_valid = 1'b0;
    #2;
    n_checks++;
    if (bus64.out_valid !== 1'b1 || bus64.out_imm !== 64'd63) begin
      n_errors++;
      $display("FAIL x64_shamt: got valid=%b imm=%0d want 1 63", bus64.out_valid, bus64.out_imm);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int           vld [8];
    int           tg  [8];
    int           rdy [8];
    logic [31:0]  held;
    int           fires;
    int           emitted[$];
    exp_t         e;
    vld   = '{1, 1, 1, 1, 1, 1, 0, 0};
    tg    = '{1, 2, 3, 3, 3, 3, 0, 0};
    rdy   = '{0, 0, 0, 0, 1, 1, 1, 1};
    fires = 0;
    held  = '0;
    sb.delete();
    for (int c = 0; c < 8; c++) begin
      bus.in_valid  = vld[c][0];
      bus.in_tag    = 8'(tg[c]);
      bus.in_fmt    = FMT_I;
      bus.in_idata  = 32'h80000000 | (32'(tg[c]) << 20);
      bus.out_ready = rdy[c][0];
      #2;
      if (c == 1) held = bus.out_imm;
      if (c == 2 || c == 3) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
          n_errors++; $display("FAIL bp_in_ready cyc=%0d: got %b want 0", c, bus.in_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 8'd1 || bus.out_imm !== held) begin
          n_errors++;
          $display("FAIL bp_hold cyc=%0d: got valid=%b tag=%0d imm=%h want 1 1 %h", c,
                   bus.out_valid, bus.out_tag, bus.out_imm, held);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(make_exp(bus.in_fmt, bus.in_idata, bus.in_tag));
        fires++;
      end
      if (bus.out_valid && bus.out_ready) begin
        emitted.push_back(int'(bus.out_tag));
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++; $display("FAIL bp_extra: got tag=%0d want none", bus.out_tag);
        end else begin
          e = sb.pop_front();
          if ({bus.out_imm, bus.out_tag, bus.out_fmt_err} !== e) begin
            n_errors++;
            $display("FAIL bp_data: got imm=%h tag=%0d want imm=%h tag=%0d", bus.out_imm,
                     bus.out_tag, e.imm, e.tag);
          end
        end
      end
      tick();
    end
    n_checks++;
    if (fires != 3 || emitted.size() != 3) begin
      n_errors++;
      $display("FAIL bp_count: got fires=%0d emitted=%0d want 3 3", fires, emitted.size());
    end else if (emitted[0] != 1 || emitted[1] != 2 || emitted[2] != 3) begin
      n_errors++;
      $display("FAIL bp_order: got %0d,%0d,%0d want 1,2,3", emitted[0], emitted[1], emitted[2]);
    end
  endtask

  task automatic test_random_stress();
    int            sent, cycles;
    logic          stall_prev;
    logic [31:0]   h_imm;
    logic [TW-1:0] h_tag;
    logic          h_err;
    exp_t          e;
    sent       = 0;
    cycles     = 0;
    stall_prev = 1'b0;
    h_imm      = '0;
    h_tag      = '0;
    h_err      = 1'b0;
    sb.delete();
    while ((sent < 10000 || sb.size() != 0) && cycles < 60000) begin
      bus.in_valid  = (sent < 10000) && ($urandom_range(9, 0) < 7);
      bus.in_fmt    = 3'($urandom_range(7, 0));
      bus.in_idata  = $urandom;
      bus.in_tag    = 8'($urandom_range(255, 0));
      bus.out_ready = (sent >= 10000) || ($urandom_range(9, 0) < 6);
      #2;
      if (stall_prev) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_imm !== h_imm || bus.out_tag !== h_tag ||
            bus.out_fmt_err !== h_err) begin
          n_errors++;
          $display("FAIL stress_stable cyc=%0d: got valid=%b imm=%h tag=%0d want 1 %h %0d",
                   cycles, bus.out_valid, bus.out_imm, bus.out_tag, h_imm, h_tag);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(make_exp(bus.in_fmt, bus.in_idata, bus.in_tag));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++; $display("FAIL stress_extra cyc=%0d: got tag=%0d want none", cycles,
                               bus.out_tag);
        end else begin
          e = sb.pop_front();
          if ({bus.out_imm, bus.out_tag, bus.out_fmt_err} !== e) begin
            n_errors++;
            $display("FAIL stress_data cyc=%0d: got imm=%h tag=%0d err=%b want %h %0d %b",
                     cycles, bus.out_imm, bus.out_tag, bus.out_fmt_err, e.imm, e.tag, e.err);
          end
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      h_imm      = bus.out_imm;
      h_tag      = bus.out_tag;
      h_err      = bus.out_fmt_err;
      tick();
      cycles++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (sent != 10000 || sb.size() != 0) begin
      n_errors++;
      $display("FAIL stress_drain: got sent=%0d pending=%0d want 10000 0", sent, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_fmt    = FMT_I;
    for (int c = 0; c < 2; c++) begin
      bus.in_valid = 1'b1;
      bus.in_tag   = 8'(8'hA0 + c);
      bus.in_idata = 32'h00500000;
      tick();
    end
    bus.in_valid = 1'b0;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL rmid_full: got out_valid=%b in_ready=%b want 1 0", bus.out_valid,
               bus.in_ready);
    end
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rmid_after: got out_valid=%b in_ready=%b want 0 1", bus.out_valid,
               bus.in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      #2;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL rmid_stale cyc=%0d: got out_valid=%b tag=%0d want 0", c, bus.out_valid,
                 bus.out_tag);
      end
    end
    tick();
  endtask

`ifdef IMM_GEN_PC_TARGET_EN
  task automatic test_pc_target();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h00001000;
    bus.in_fmt    = FMT_B;
    bus.in_idata  = 32'hFE0008E3;
    tick();
    bus.in_fmt    = FMT_I;
    #2;
    n_checks++;
    if (bus.out_imm !== 32'hFFFFFFF0 || bus.out_target !== 32'h00000FF0) begin
      n_errors++;
      $display("FAIL pc_target_b: got imm=%h target=%h want fffffff0 00000ff0", bus.out_imm,
               bus.out_target);
    end
    tick();
    bus.in_valid = 1'b0;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_target !== 32'd0) begin
      n_errors++;
      $display("FAIL pc_target_i: got valid=%b target=%h want 1 0", bus.out_valid,
               bus.out_target);
    end
    tick();
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_format_sweep();
    test_xlen64();
    test_backpressure();
    test_random_stress();
    test_reset_mid();
`ifdef IMM_GEN_PC_TARGET_EN
    test_pc_target();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
